// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared command encodings, grant-state type and the
// address-to-slave decode used by the crossbar_rr interconnect.
package crossbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } grant_state_t;

  // Slave select is the top sel_w bits of an addr_w-bit address. The address
  // is passed zero-extended to 64 bits so one function serves every width.
  function automatic logic [3:0] sel_of(input logic [63:0] addr,
                                        input int addr_w,
                                        input int sel_w);
    logic [63:0] shifted;
    shifted = addr >> (addr_w - sel_w);
    return shifted[3:0] & 4'((1 << sel_w) - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way arbiter returning a one-hot grant and its binary index.
// Round-robin from a rotating pointer, or fixed priority (lowest index wins,
// no pointer) when FIXED_PRIO is set. The pointer moves past the current
// winner when 'advance' is pulsed.
module rr_arbiter #(
  parameter int N          = 4,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] base;
  logic          found;
  int            c;

  generate
    if (FIXED_PRIO) begin : g_fixed
      logic unused_fixed;
      assign unused_fixed = ^{clk, reset, advance};
      assign base = '0;
    end else begin : g_rr
      logic [IW-1:0] ptr_reg;

      // Rotate the search start to just past the master that was served
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ptr_reg <= '0;
        end else if (advance) begin
          ptr_reg <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
      end

      assign base = ptr_reg;
    end
  endgenerate

  // First requester found scanning upward from base, wrapping at N
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(base) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/crossbar_rr.sv
// crossbar_rr: N_MASTERS x N_SLAVES request/ack/resp interconnect with one
// arbiter and grant FSM per slave, so distinct slaves serve distinct masters
// concurrently. Read responses return through a per-slave in-order queue of
// master IDs. Each master may have at most one read outstanding.
// Build option: define CROSSBAR_FIXED_PRIO_EN to make every slave arbiter
// fixed priority (lowest master index wins) instead of round-robin.
module crossbar_rr
  import crossbar_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = $clog2(N_SLAVES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_resp,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_SLAVES-1:0]           s_req,
  output logic [N_SLAVES-1:0]           s_cmd,
  output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
  output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
  input  logic [N_SLAVES-1:0]           s_ack,
  input  logic [N_SLAVES-1:0]           s_resp,
  input  logic [N_SLAVES*DATA_W-1:0]    s_rdata
);

`ifdef CROSSBAR_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam int MIDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNTW = $clog2(N_MASTERS + 1);

  logic [SEL_W-1:0]              m_sel [N_MASTERS];
  logic [N_MASTERS-1:0]          rd_pending_reg;
  logic [N_MASTERS-1:0]          rd_blocked;
  logic [N_MASTERS-1:0]          ack_raw;
  logic [N_MASTERS-1:0]          rd_ack;
  logic [N_MASTERS-1:0]          resp_raw;
  logic [N_MASTERS*DATA_W-1:0]   rdata_raw;

  logic [N_SLAVES-1:0]           fire;
  logic [N_SLAVES-1:0]           push_vec;
  logic [N_SLAVES-1:0]           resp_hit;
  logic [N_SLAVES-1:0]           resp_orphan;
  logic [MIDW-1:0]               winner [N_SLAVES];
  logic [MIDW-1:0]               head   [N_SLAVES];
  logic [4:0]                    orphan_cnt;
  logic [15:0]                   resp_err_cnt_reg;

  genvar gi;

  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_decode
      assign m_sel[gi] = SEL_W'(sel_of(64'(m_addr[gi*ADDR_W +: ADDR_W]), ADDR_W, SEL_W));
    end
  endgenerate

  // A response delivered this cycle already frees its master, so the next
  // read can be registered at the same edge and reach the slave a cycle later
  assign rd_blocked = rd_pending_reg & ~resp_raw;

  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      grant_state_t         state_reg;
      logic [MIDW-1:0]      winner_reg;
      logic [N_MASTERS-1:0] elig;
      logic [N_MASTERS-1:0] arb_req;
      logic [N_MASTERS-1:0] arb_grant;
      logic [MIDW-1:0]      arb_idx;
      logic                 live;
      logic [MIDW-1:0]      q_mem [N_MASTERS];
      logic [MIDW-1:0]      rd_ptr_reg;
      logic [MIDW-1:0]      wr_ptr_reg;
      logic [CNTW-1:0]      count_reg;

      // Masters requesting this slave that have no read in flight
      always_comb begin
        elig = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
          elig[i] = m_req[i] && (m_sel[i] == SEL_W'(gi)) && !rd_blocked[i];
        end
      end

      // While granted, present only the winner so the arbiter index (and the
      // pointer update on ack) refers to the master actually being served
      assign arb_req = (state_reg == GRANT) ? (N_MASTERS'(1) << winner_reg) : elig;

      rr_arbiter #(
        .N          (N_MASTERS),
        .FIXED_PRIO (FIXED_PRIO)
      ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (fire[gi]),
        .grant   (arb_grant),
        .idx     (arb_idx)
      );

      assign live        = (state_reg == GRANT) && m_req[winner_reg];
      assign fire[gi]    = live && s_ack[gi];
      assign winner[gi]  = winner_reg;
      assign push_vec[gi] = fire[gi] && (m_cmd[winner_reg] == CMD_READ);

      // Grant FSM: latch a winner, hold until ack or until the master withdraws
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg  <= IDLE;
          winner_reg <= '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (|arb_grant) begin
                state_reg  <= GRANT;
                winner_reg <= arb_idx;
              end
            end
            GRANT: begin
              if (!live || s_ack[gi]) state_reg <= IDLE;
            end
          endcase
        end
      end

      assign s_req[gi] = reset & live;
      assign s_cmd[gi] = reset & live & m_cmd[winner_reg];
      assign s_addr[gi*ADDR_W +: ADDR_W] =
        (reset && live) ? m_addr[winner_reg*ADDR_W +: ADDR_W] : '0;
      assign s_wdata[gi*DATA_W +: DATA_W] =
        (reset && live) ? m_wdata[winner_reg*DATA_W +: DATA_W] : '0;

      // Response routing queue; with one read per master it never overflows
      assign resp_hit[gi]    = s_resp[gi] && (count_reg != '0);
      assign resp_orphan[gi] = s_resp[gi] && (count_reg == '0);
      assign head[gi]        = q_mem[rd_ptr_reg];

      // Queue storage: record which master each accepted read belongs to
      always_ff @(posedge clk) begin
        if (push_vec[gi]) q_mem[wr_ptr_reg] <= winner_reg;
      end

      // Queue pointers and occupancy; push and pop together leave count as is
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_vec[gi]) begin
            wr_ptr_reg <= (wr_ptr_reg == MIDW'(N_MASTERS - 1)) ? '0 : wr_ptr_reg + 1'b1;
          end
          if (resp_hit[gi]) begin
            rd_ptr_reg <= (rd_ptr_reg == MIDW'(N_MASTERS - 1)) ? '0 : rd_ptr_reg + 1'b1;
          end
          case ({push_vec[gi], resp_hit[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Fold per-slave acks and responses back onto the master side
  always_comb begin
    ack_raw    = '0;
    rd_ack     = '0;
    resp_raw   = '0;
    rdata_raw  = '0;
    orphan_cnt = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (fire[j])     ack_raw[winner[j]] = 1'b1;
      if (push_vec[j]) rd_ack[winner[j]]  = 1'b1;
      if (resp_hit[j]) begin
        resp_raw[head[j]] = 1'b1;
        rdata_raw[head[j]*DATA_W +: DATA_W] = s_rdata[j*DATA_W +: DATA_W];
      end
      if (resp_orphan[j]) orphan_cnt = orphan_cnt + 5'd1;
    end
  end

  // One-outstanding-read tracking per master
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending_reg <= '0;
    end else begin
      rd_pending_reg <= (rd_pending_reg & ~resp_raw) | rd_ack;
    end
  end

  // Count responses that arrive with no read outstanding at that slave
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_err_cnt_reg <= '0;
    end else begin
      resp_err_cnt_reg <= resp_err_cnt_reg + 16'(orphan_cnt);
    end
  end

  assign m_ack   = ack_raw & {N_MASTERS{reset}};
  assign m_resp  = resp_raw & {N_MASTERS{reset}};
  assign m_rdata = reset ? rdata_raw : '0;

endmodule

// File: tb/tb_crossbar_rr.sv
// tb_crossbar_rr: directed scenarios for the 4x4 crossbar_rr: reset,
// round-robin order, concurrency, read routing, outstanding-read limit and
// arbitration priority (CROSSBAR_FIXED_PRIO_EN selects fixed-priority
// expectations).
module tb_crossbar_rr;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   m_req, m_cmd, m_ack, m_resp;
  logic [127:0] m_addr, m_wdata, m_rdata;
  logic [3:0]   s_req, s_cmd, s_ack, s_resp;
  logic [127:0] s_addr, s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crossbar_rr #(
    .N_MASTERS (4),
    .N_SLAVES  (4),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_cmd   (m_cmd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_resp  (m_resp),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_cmd   (s_cmd),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_resp  (s_resp),
    .s_rdata (s_rdata)
  );

  task automatic set_m(input int i, input logic cmd, input logic [31:0] addr,
                       input logic [31:0] wd);
    m_req[i] = 1'b1;
    m_cmd[i] = cmd;
    m_addr[i*32 +: 32]  = addr;
    m_wdata[i*32 +: 32] = wd;
  endtask

  // Wait (bounded) for slave j to request, ack it, return the m_ack seen
  task automatic serve_one(input int j, output logic [3:0] acked, output bit ok);
    int c;
    c = 0;
    ok = 1'b0;
    acked = '0;
    while (!ok && c < 20) begin
      @(negedge clk);
      c++;
      if (s_req[j]) begin
        s_ack[j] = 1'b1;
        #1;
        acked = m_ack;
        ok = 1'b1;
        @(posedge clk);
        #1;
        s_ack[j] = 1'b0;
      end
    end
    $display("txn slave %0d m_ack %b served %0d", j, acked, ok);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_ack, m_resp, s_req, s_cmd} !== 16'h0) begin
      errors++; $display("FAIL reset_idle got %h want 0", {m_ack, m_resp, s_req, s_cmd});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 32'h0000_0010, 32'h100 + i);
    @(negedge clk);
    checks++;
    if (s_req !== 4'b0000) begin
      errors++; $display("FAIL reset_latency0 got %b want 0000", s_req);
    end
    @(negedge clk);
    checks++;
    if ({s_req, s_wdata[31:0]} !== {4'b0001, 32'h100}) begin
      errors++; $display("FAIL reset_grant got %b/%h want 0001/100", s_req, s_wdata[31:0]);
    end
    s_ack[0] = 1'b1; s_resp = 4'hF; s_rdata = {4{32'hDEAD_BEEF}};
    #1;
    checks++;
    if (m_ack !== 4'b0001) begin
      errors++; $display("FAIL reset_preack got %b want 0001", m_ack);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({s_req, s_cmd, m_ack, m_resp} !== 16'h0) begin
      errors++; $display("FAIL reset_async_ctl got %h want 0", {s_req, s_cmd, m_ack, m_resp});
    end
    checks++;
    if ((s_addr | s_wdata | m_rdata) !== 128'h0) begin
      errors++; $display("FAIL reset_async_data got %h want 0", s_addr | s_wdata | m_rdata);
    end
    s_ack = '0; s_resp = '0; s_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (s_req !== 4'b0000) begin
      errors++; $display("FAIL reset_release got %b want 0000", s_req);
    end
    @(negedge clk);
    checks++;
    if ({s_req, s_addr[31:0]} !== {4'b0001, 32'h0000_0010}) begin
      errors++; $display("FAIL reset_first_req got %b/%h want 0001/10", s_req, s_addr[31:0]);
    end
    @(posedge clk); #1;
    m_req = '0;
    @(negedge clk);
    checks++;
    if ({s_req, m_ack} !== 8'h0) begin
      errors++; $display("FAIL withdraw got %b/%b want 0/0", s_req, m_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack [5];
    logic [3:0] acked;
    bit ok;
`ifdef CROSSBAR_FIXED_PRIO_EN
    exp_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 32'h0000_0010, 32'h200 + i);
    for (int n = 0; n < 5; n++) begin
      serve_one(0, acked, ok);
      checks++;
      if (!ok || acked !== exp_ack[n]) begin
        errors++; $display("FAIL rr_ack%0d got %b (served %0d) want %b", n, acked, ok, exp_ack[n]);
      end
    end
    m_req = '0;
  endtask

  task automatic test_concurrency();
    set_m(0, 1'b1, 32'h0000_0000, 32'hA0);
    set_m(1, 1'b1, 32'h4000_0000, 32'hA1);
    @(negedge clk);
    checks++;
    if (s_req !== 4'b0000) begin
      errors++; $display("FAIL conc_latency got %b want 0000", s_req);
    end
    @(negedge clk);
    checks++;
    if ({s_req, s_cmd} !== 8'b0011_0011) begin
      errors++; $display("FAIL conc_req got %b/%b want 0011/0011", s_req, s_cmd);
    end
    checks++;
    if ({s_addr[63:0], s_wdata[63:0]} !== {32'h4000_0000, 32'h0, 32'hA1, 32'hA0}) begin
      errors++; $display("FAIL conc_mux got %h/%h", s_addr[63:0], s_wdata[63:0]);
    end
    s_ack = 4'b0011;
    #1;
    checks++;
    if (m_ack !== 4'b0011) begin
      errors++; $display("FAIL conc_ack got %b want 0011", m_ack);
    end
    $display("txn concurrent m_ack %b", m_ack);
    @(posedge clk); #1;
    s_ack = '0; m_req = '0;
    @(negedge clk);
    checks++;
    if (s_req !== 4'b0000) begin
      errors++; $display("FAIL conc_gap got %b want 0000", s_req);
    end
  endtask

  task automatic test_read_routing();
    logic [3:0] acked;
    bit ok;
    set_m(2, 1'b0, 32'h8000_0004, 32'h0);
    set_m(3, 1'b0, 32'h8000_0008, 32'h0);
    serve_one(2, acked, ok);
    checks++;
    if (!ok || acked !== 4'b0100) begin
      errors++; $display("FAIL rd_ack_m2 got %b (served %0d) want 0100", acked, ok);
    end
    m_req[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (s_req[2] !== 1'b0) begin
      errors++; $display("FAIL rd_gap got %b want 0", s_req[2]);
    end
    @(negedge clk);
    checks++;
    if ({s_req[2], s_addr[95:64]} !== {1'b1, 32'h8000_0008}) begin
      errors++; $display("FAIL rd_req_m3 got %b/%h want 1/80000008", s_req[2], s_addr[95:64]);
    end
    s_ack[2] = 1'b1; s_resp[2] = 1'b1; s_rdata[95:64] = 32'h0000_AAAA;
    #1;
    checks++;
    if ({m_ack, m_resp} !== 8'b1000_0100) begin
      errors++; $display("FAIL rd_resp_m2 got ack %b resp %b want 1000/0100", m_ack, m_resp);
    end
    checks++;
    if (m_rdata !== {32'h0, 32'h0000_AAAA, 64'h0}) begin
      errors++; $display("FAIL rd_data_m2 got %h want AAAA on m2 only", m_rdata);
    end
    $display("txn read resp m_resp %b", m_resp);
    @(posedge clk); #1;
    s_ack = '0; m_req[3] = 1'b0; s_rdata[95:64] = 32'h0000_BBBB;
    @(negedge clk);
    checks++;
    if (m_resp !== 4'b1000) begin
      errors++; $display("FAIL rd_resp_m3 got %b want 1000", m_resp);
    end
    checks++;
    if (m_rdata !== {32'h0000_BBBB, 96'h0}) begin
      errors++; $display("FAIL rd_data_m3 got %h want BBBB on m3 only", m_rdata);
    end
    $display("txn read resp m_resp %b", m_resp);
    @(posedge clk); #1;
    s_resp = '0; s_rdata = '0;
    @(posedge clk); #1;
    s_resp[2] = 1'b1; s_rdata[95:64] = 32'h0000_CCCC;
    @(negedge clk);
    checks++;
    if ({m_resp, m_rdata} !== 132'h0) begin
      errors++; $display("FAIL rd_orphan got %b/%h want 0/0", m_resp, m_rdata);
    end
    @(posedge clk); #1;
    s_resp = '0; s_rdata = '0;
  endtask

  task automatic test_outstanding();
    logic [3:0] acked;
    bit ok;
    logic withheld;
    set_m(1, 1'b0, 32'hC000_0000, 32'h0);
    serve_one(3, acked, ok);
    checks++;
    if (!ok || acked !== 4'b0010) begin
      errors++; $display("FAIL out_ack1 got %b (served %0d) want 0010", acked, ok);
    end
    m_addr[63:32] = 32'hC000_0004;
    withheld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      withheld = withheld | s_req[3];
    end
    @(negedge clk);
    s_resp[3] = 1'b1; s_rdata[127:96] = 32'h1234_5678;
    #1;
    withheld = withheld | s_req[3];
    checks++;
    if (withheld !== 1'b0) begin
      errors++; $display("FAIL out_withheld got %b want 0", withheld);
    end
    checks++;
    if ({m_resp, m_rdata[63:32]} !== {4'b0010, 32'h1234_5678}) begin
      errors++; $display("FAIL out_resp got %b/%h want 0010/12345678", m_resp, m_rdata[63:32]);
    end
    @(posedge clk); #1;
    s_resp = '0; s_rdata = '0;
    @(negedge clk);
    checks++;
    if ({s_req[3], s_addr[127:96]} !== {1'b1, 32'hC000_0004}) begin
      errors++; $display("FAIL out_second_req got %b/%h want 1/C0000004", s_req[3], s_addr[127:96]);
    end
    s_ack[3] = 1'b1;
    #1;
    checks++;
    if (m_ack !== 4'b0010) begin
      errors++; $display("FAIL out_ack2 got %b want 0010", m_ack);
    end
    $display("txn second read m_ack %b", m_ack);
    @(posedge clk); #1;
    s_ack = '0; m_req[1] = 1'b0;
    @(negedge clk);
    s_resp[3] = 1'b1; s_rdata[127:96] = 32'h0000_0055;
    #1;
    checks++;
    if ({m_resp, m_rdata[63:32]} !== {4'b0010, 32'h0000_0055}) begin
      errors++; $display("FAIL out_resp2 got %b/%h want 0010/55", m_resp, m_rdata[63:32]);
    end
    @(posedge clk); #1;
    s_resp = '0; s_rdata = '0;
  endtask

  task automatic test_prio();
    logic [3:0] exp_ack [3];
    logic [3:0] acked;
    bit ok;
`ifdef CROSSBAR_FIXED_PRIO_EN
    exp_ack = '{4'b0001, 4'b0001, 4'b0001};
`else
    exp_ack = '{4'b0100, 4'b0001, 4'b0100};
`endif
    set_m(0, 1'b1, 32'h4000_0020, 32'hB0);
    set_m(2, 1'b1, 32'h4000_0030, 32'hB2);
    for (int n = 0; n < 3; n++) begin
      serve_one(1, acked, ok);
      checks++;
      if (!ok || acked !== exp_ack[n]) begin
        errors++; $display("FAIL prio_ack%0d got %b (served %0d) want %b", n, acked, ok, exp_ack[n]);
      end
    end
    m_req[0] = 1'b0;
    serve_one(1, acked, ok);
    checks++;
    if (!ok || acked !== 4'b0100) begin
      errors++; $display("FAIL prio_after_drop got %b (served %0d) want 0100", acked, ok);
    end
    m_req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_concurrency();
    test_read_routing();
    test_outstanding();
    test_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crossbar_rr.md
Name: crossbar_rr

Overview:
- Parametrised N-master x M-slave request/ack/resp interconnect; successor to the fixed 4x4 crossbar.
- Each slave has its own round-robin arbiter, so different slaves serve different masters concurrently.
- Read responses are routed back through per-slave in-order master-ID queues.
- Sits between CPU/DMA masters and memory/peripheral slaves.

Parameters:
- N_MASTERS, 4, number of masters (2..16).
- N_SLAVES, 4, number of slaves; power of 2 (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_W, $clog2(N_SLAVES), derived; slave select = addr[ADDR_W-1 -: SEL_W].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- m_req  in  N_MASTERS  per-master transaction request
- m_cmd  in  N_MASTERS  0 read, 1 write
- m_addr  in  N_MASTERS*ADDR_W  flattened addresses
- m_wdata  in  N_MASTERS*DATA_W  flattened write data
- m_ack  out  N_MASTERS  transaction accepted
- m_resp  out  N_MASTERS  read data valid
- m_rdata  out  N_MASTERS*DATA_W  read data; zero when m_resp is low
- s_req  out  N_SLAVES  request to slave
- s_cmd  out  N_SLAVES  command to slave
- s_addr  out  N_SLAVES*ADDR_W  address to slave; zero when idle
- s_wdata  out  N_SLAVES*DATA_W  write data; zero when idle
- s_ack  in  N_SLAVES  slave accepted
- s_resp  in  N_SLAVES  slave read data valid
- s_rdata  in  N_SLAVES*DATA_W  slave read data

Behaviour:
- Reset (reset=0, asynchronous):
  - all grants idle; RR pointers = 0; ID queues empty; rd_pending = 0.
  - All outputs 0, combinationally forced, not only at the next edge.
- Decode:
  - Master i targets slave addr_i[ADDR_W-1 -: SEL_W].
  - A master holds req, cmd, addr and wdata stable until m_ack.
- Eligibility: master i is eligible for slave j if req_i=1, it decodes to j, and rd_pending[i]=0.
  - rd_pending[i] is set when master i's read is acked; it is cleared when master i's resp is delivered.
  - A master therefore has at most one outstanding read; writes are not limited.
- Per-slave grant FSM, IDLE -> GRANT:
  - IDLE: if any eligible master exists, register the winner (round-robin from ptr_j) and go to GRANT at the next edge.
  - GRANT: s_req_j=1, with cmd/addr/wdata muxed from the winner.
  - On s_ack_j=1: m_ack_winner=1 in the same cycle (combinational); ptr_j <= winner+1 mod N_MASTERS; return to IDLE.
  - Latency: m_req to s_req is 1 cycle. After an ack, s_req_j is low for at least 1 cycle.
  - If the winner drops req before ack (protocol violation): s_req drops, FSM returns to IDLE, pointer unchanged.
- Read ID queue per slave:
  - Depth N_MASTERS; it cannot overflow because of the one-outstanding-read limit.
  - Push the winner ID on s_ack_j & ~cmd; pop on s_resp_j.
  - Push and pop in the same cycle are allowed, count unchanged.
  - s_resp_j with the queue empty is ignored and counted as an error.
- Resp routing: m_resp_k = s_resp_j for the queue-head ID k of slave j; m_rdata_k = s_rdata_j.
  - Simultaneous resps from different slaves reach different masters in the same cycle; no stall.
- Slaves must assert resp no earlier than the cycle after ack, and respond in order.
- Writes produce no resp.

Optional Feature:
- CROSSBAR_FIXED_PRIO_EN defined: every per-slave arbiter uses fixed priority (lowest master index wins); pointers are not instantiated.
- Undefined (default): round-robin as above.

Decomposition:
- Package crossbar_pkg holds:
  - CMD_READ / CMD_WRITE constants.
  - slave-select function sel_of(addr).
  - grant-state enum {IDLE, GRANT}.
- One sub-module, rr_arbiter (params N, FIXED_PRIO): inputs req vector and advance; outputs a one-hot grant plus a binary index. It is instantiated per slave.
- ID queues are inline in crossbar_rr.

Test Plan:
- Reset: assert reset=0 mid-GRANT with m_req=4'b1111 -> all outputs 0 immediately; after release, first s_req appears 1 cycle after the first clk edge.
- Round-robin: masters 0..3 all write 0x0000_0010 (slave 0) with s_ack after 1 cycle -> m_ack order is 0,1,2,3,0; each master is acked exactly once per 4 grants.
- Concurrency: M0 -> 0x0000_0000 and M1 -> 0x4000_0000 in the same cycle -> s_req[0] and s_req[1] both high on the same cycle; both m_acks arrive in the same cycle.
- Read routing: M2 reads 0x8000_0004 and M3 reads 0x8000_0008 from slave 2; slave responds 0xAAAA then 0xBBBB -> m_resp[2] gets 0xAAAA, then m_resp[3] gets 0xBBBB; other m_rdata stay 0.
- Outstanding limit: M1 reads slave 3 with resp delayed 5 cycles, and M1 issues a second read -> the second s_req is withheld until the cycle after m_resp[1].
- CROSSBAR_FIXED_PRIO_EN: masters 0 and 2 request slave 1 continuously -> master 0 wins every grant; master 2 wins only once master 0 drops req.
